shift_rotate_seq: RTL and testbench

- Multi-cycle shift/rotate execution unit for the CPU datapath ALU.
- Takes operand A and count B from the bus-side operand registers and shifts or rotates one bit per clock.
- Returns a registered 32-bit result plus a carry-out flag to the Z-register write path, using a start/busy/done handshake.
- Replaces the area of per-amount combinational rotate muxes with a small sequential engine.
- Supported ops: SHL, SHR, SHRA, ROL, ROR.

---
 rtl/shift_rotate_seq.sv | 122 ++++++++++++
 tb/tb_shift_rotate_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rotate_seq.sv
// Sequential shift/rotate engine: moves one bit per clock and reports the result and carry-out
// through a start/busy/done handshake.
module shift_rotate_seq #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             err
);

  localparam logic [2:0] OP_SHL  = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHRA = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [CNT_BITS-1:0] cnt_q;
  logic [2:0]          op_q;
  logic                bit_out_d;
  logic                busy_q, done_q, cout_q, err_q;
  logic [WIDTH-1:0]    result_q;
  logic                op_illegal;
  logic                unused_b;

  assign op_illegal = (op > OP_ROR);
  assign unused_b   = ^b[WIDTH-1:CNT_BITS];

  // One-bit step of the latched op; bit_out_d is the bit leaving the accumulator.
  always_comb begin
    acc_d     = acc_q;
    bit_out_d = 1'b0;
    case (op_q)
      OP_SHL:  begin acc_d = {acc_q[WIDTH-2:0], 1'b0};         bit_out_d = acc_q[WIDTH-1]; end
      OP_SHR:  begin acc_d = {1'b0, acc_q[WIDTH-1:1]};         bit_out_d = acc_q[0];       end
      OP_SHRA: begin acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]}; bit_out_d = acc_q[0];     end
      OP_ROL:  begin acc_d = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]}; bit_out_d = acc_q[WIDTH-1]; end
      OP_ROR:  begin acc_d = {acc_q[0], acc_q[WIDTH-1:1]};     bit_out_d = acc_q[0];       end
      default: begin acc_d = acc_q;                            bit_out_d = 1'b0;           end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            acc_q  <= a;
            cnt_q  <= b[CNT_BITS-1:0];
            op_q   <= op;
            busy_q <= 1'b1;
            // Zero count and illegal ops finish on the accepting edge with a unchanged.
            if (op_illegal || (b[CNT_BITS-1:0] == '0)) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= a;
              cout_q   <= 1'b0;
              err_q    <= op_illegal;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == {{(CNT_BITS-1){1'b0}}, 1'b1}) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= acc_d;
              cout_q   <= bit_out_d;
              err_q    <= 1'b0;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign err    = err_q;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Self-checking bench: an arithmetic reference model compared every cycle, plus directed
// vectors with hand-computed results, latencies and handshake cases.
module tb_shift_rotate_seq;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic        flush = 1'b0;
  logic        busy, done, cout, err;
  logic [31:0] result;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  shift_rotate_seq #(.WIDTH(32), .CNT_BITS(5)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .result(result), .cout(cout), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Final value of an op computed directly from the shift amount.
  task automatic calc(input logic [2:0] o, input logic [31:0] x, input int n,
                      output logic [31:0] res, output logic co, output logic er);
    logic [63:0]        w;
    logic signed [63:0] s;
    er  = (o > 3'd4);
    res = x;
    co  = 1'b0;
    if (!er && n != 0) begin
      case (o)
        3'd0: begin w = {32'd0, x} << n; res = w[31:0];  co = w[32]; end
        3'd1: begin w = {x, 32'd0} >> n; res = w[63:32]; co = w[31]; end
        3'd2: begin s = {x, 32'd0}; s = s >>> n; res = s[63:32]; co = s[31]; end
        3'd3: begin res = (x << n) | (x >> (32 - n)); co = res[0];  end
        default: begin res = (x >> n) | (x << (32 - n)); co = res[31]; end
      endcase
    end
  endtask

  // Transaction-level reference: output values are known at accept time, then revealed after a countdown.
  logic        m_busy = 0, m_done = 0, m_cout = 0, m_err = 0;
  logic [31:0] m_result = 0;
  logic [31:0] p_res;
  logic        p_co, p_er;
  int          m_rem = 0;

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      m_busy = 0; m_done = 0; m_cout = 0; m_err = 0; m_result = 0; m_rem = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (flush) begin
          m_busy = 0; m_rem = 0;
        end else if (m_rem == 0) begin
          m_busy = 0;
        end else begin
          m_rem--;
          if (m_rem == 0) begin
            m_done = 1; m_result = p_res; m_cout = p_co; m_err = p_er;
          end
        end
      end else if (start && !flush) begin
        calc(op, a, int'(b[4:0]), p_res, p_co, p_er);
        m_busy = 1;
        if (p_er || b[4:0] == 5'd0) begin
          m_rem = 0; m_done = 1; m_result = p_res; m_cout = p_co; m_err = p_er;
        end else begin
          m_rem = int'(b[4:0]);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model busy",   {31'd0, busy}, {31'd0, m_busy});
      check("model done",   {31'd0, done}, {31'd0, m_done});
      check("model result", result,        m_result);
      check("model cout",   {31'd0, cout}, {31'd0, m_cout});
      check("model err",    {31'd0, err},  {31'd0, m_err});
    end
  end

  // Issue one op, scramble inputs after the accepting edge, wait (bounded) for done.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_res, input logic exp_co,
                        input logic exp_er, input int exp_lat);
    int lat = -1;
    @(negedge clock);
    start = 1; op = o; a = x; b = y;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (k == 1) begin
        start = 0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
      end
      if (done) begin lat = k; break; end
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"},  result, exp_res);
    check({name, " cout"},    {31'd0, cout}, {31'd0, exp_co});
    check({name, " err"},     {31'd0, err},  {31'd0, exp_er});
  endtask

  initial begin
    int          cnt;
    int          lat;
    logic [31:0] r;
    logic        c, e;
    int          counts [4] = '{1, 5, 16, 31};

    repeat (3) @(negedge clock);
    check("reset busy",   {31'd0, busy}, 32'd0);
    check("reset done",   {31'd0, done}, 32'd0);
    check("reset result", result,        32'd0);
    check("reset cout",   {31'd0, cout}, 32'd0);
    check("reset err",    {31'd0, err},  32'd0);
    #2 clear = 1;
    chk_en = 1;

    // Pin the reference model against hand values.
    calc(3'd2, 32'hF000_0000, 4, r, c, e);
    check("calc shra", r, 32'hFF00_0000);
    calc(3'd4, 32'h0000_0001, 4, r, c, e);
    check("calc ror", r, 32'h1000_0000);
    calc(3'd0, 32'h0000_0003, 31, r, c, e);
    check("calc shl cout", {31'd0, c}, 32'd1);

    run_op("rol1",    3'd3, 32'h8000_0001, 32'd1,  32'h0000_0003, 1'b1, 1'b0, 2);
    run_op("ror4",    3'd4, 32'h0000_0001, 32'd4,  32'h1000_0000, 1'b0, 1'b0, 5);
    run_op("rol28",   3'd3, 32'h0000_0001, 32'd28, 32'h1000_0000, 1'b0, 1'b0, 29);
    run_op("shra4",   3'd2, 32'hF000_0000, 32'd4,  32'hFF00_0000, 1'b0, 1'b0, 5);
    run_op("shr4",    3'd1, 32'hF000_0000, 32'd4,  32'h0F00_0000, 1'b0, 1'b0, 5);
    run_op("cnt0",    3'd1, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 1'b0, 1'b0, 1);
    run_op("illegal", 3'd6, 32'hDEAD_BEEF, 32'd5,  32'hDEAD_BEEF, 1'b0, 1'b1, 1);

    // SHL by 31 (upper b bits ignored) with a second start mid-run that must be dropped.
    @(negedge clock);
    start = 1; op = 3'd0; a = 32'h1; b = 32'h0000_0FFF;
    lat = -1; cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (k == 1)  start = 0;
      if (k == 10) begin start = 1; op = 3'd4; a = 32'h55; b = 32'd3; end
      if (k == 11) start = 0;
      if (!busy) cnt++;
      if (done) begin lat = k; break; end
    end
    check("shl31 latency", lat, 32);
    check("shl31 result", result, 32'h8000_0000);
    check("shl31 busy low cycles", cnt, 0);

    // Sweep every legal op over several counts.
    for (int o = 0; o < 5; o++)
      for (int i = 0; i < 4; i++) begin
        calc(3'(o), 32'hC3A5_0F96, counts[i], r, c, e);
        run_op("sweep", 3'(o), 32'hC3A5_0F96, 32'(counts[i]), r, c, e, counts[i] + 1);
      end

    // start held high: accepted every N+2 cycles, never in the DONE cycle.
    @(negedge clock);
    start = 1; op = 3'd3; a = 32'h0000_00F0; b = 32'd2;
    cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (done) cnt++;
    end
    start = 0;
    check("back-to-back dones", cnt, 3);
    repeat (4) @(negedge clock);

    // flush beats start in IDLE.
    run_op("pre-flush", 3'd1, 32'hF000_0000, 32'd4, 32'h0F00_0000, 1'b0, 1'b0, 5);
    @(negedge clock);
    start = 1; flush = 1; op = 3'd0; a = 32'hFFFF_FFFF; b = 32'd3;
    @(negedge clock);
    start = 0; flush = 0;
    check("flush idle busy", {31'd0, busy}, 32'd0);

    // flush mid-RUN: no done, previous outputs retained.
    @(negedge clock);
    start = 1; op = 3'd3; a = 32'hAAAA_5555; b = 32'd20;
    cnt = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      if (k == 1) start = 0;
      if (k == 5) flush = 1;
      if (k == 6) flush = 0;
      if (done) cnt++;
    end
    check("flush no done", cnt, 0);
    check("flush result kept", result, 32'h0F00_0000);
    check("flush busy", {31'd0, busy}, 32'd0);

    // Asynchronous clear mid-RUN.
    @(negedge clock);
    start = 1; op = 3'd3; a = 32'h1234_5678; b = 32'd20;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (k == 1) start = 0;
    end
    #2 clear = 0;
    #1;
    check("clear busy",   {31'd0, busy}, 32'd0);
    check("clear done",   {31'd0, done}, 32'd0);
    check("clear result", result,        32'd0);
    check("clear cout",   {31'd0, cout}, 32'd0);
    check("clear err",    {31'd0, err},  32'd0);
    repeat (2) @(negedge clock);
    #2 clear = 1;
    cnt = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      if (done) cnt++;
    end
    check("clear no done", cnt, 0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
